instr_fetch: RTL and testbench
==============================

# instr_fetch

Instruction fetch stage for the single-cycle-ROM CPU. It owns the program counter and drives the ROM address lines. It compensates for the ROM's one-cycle registered read and presents fetched words to the decoder over a valid/ready handshake. It also supports stall (back-pressure) and branch redirection.

## Interface
- `ADDR_WIDTH`, default 3: program counter / ROM address width; must match the ROM instance.
- `DATA_WIDTH`, default 32: instruction word width; must match the ROM instance.

Ports:
- `clk`  in  1  system clock; all state changes on rising edge.
- `rst`  in  1  reset; asynchronous and active-high.
- `rom_addr`  out  ADDR_WIDTH  ROM read address; combinational from internal state plus `branch_en` and `instr_ready`.
- `rom_q`  in  DATA_WIDTH  ROM registered read data; holds mem[address presented at the previous edge].
- `branch_en`  in  1  one-cycle redirect request.
- `branch_addr`  in  ADDR_WIDTH  redirect target; sampled when `branch_en`=1.
- `instr`  out  DATA_WIDTH  fetched instruction.
- `instr_pc`  out  ADDR_WIDTH  address of `instr`.
- `instr_valid`  out  1  `instr`/`instr_pc` hold a valid word.
- `instr_ready`  in  1  decoder accepts the word this cycle.
- `stall_cnt`  out  32  present only with `INSTR_FETCH_STALL_CNT_EN`.

## Operation
- Internal registers:
  - `req_pc`: address whose data is currently on `rom_q`.
  - `req_vld`: `rom_q` holds a correct-path word.
  - Output registers: `instr`, `instr_pc`, `instr_valid`.
- Reset values: `req_pc`=0, `req_vld`=0, `instr`=0, `instr_pc`=0, `instr_valid`=0, `stall_cnt`=0. While `rst`=1, `rom_addr`=0.
- Two-state FSM:
  - PRIME (entered on reset): `req_vld`=0. The first clock edge after `rst` deasserts moves to RUN and sets `req_vld`=1. At that same edge the ROM latches mem[0].
  - RUN: stays in RUN until reset.
- `advance` = `req_vld` & (!`instr_valid` | `instr_ready`).
- `rom_addr` priority:
  1. `branch_en` → `branch_addr`.
  2. else `advance` → `req_pc`+1.
  3. else `req_pc`, so the ROM re-reads the same word and `rom_q` stays stable during a stall.
- On `advance` without branch, at the clock edge:
  - `instr`<=`rom_q`, `instr_pc`<=`req_pc`, `instr_valid`<=1.
  - `req_pc`<=`req_pc`+1.
- If `instr_valid` & `instr_ready` & !`req_vld`, then `instr_valid`<=0.
- PC arithmetic is modulo 2^ADDR_WIDTH. Address 2^ADDR_WIDTH−1 wraps to 0 with no flag.
- Branch handling (`branch_en`=1):
  - Updates: `req_pc`<=`branch_addr`, `req_vld`<=1, `instr_valid`<=0.
  - The wrong-path word on `rom_q` is discarded.
  - Branch overrides `advance` and stall.
  - If `instr_ready`=1 in the same cycle, the handshake on the current output word still completes (the decoder consumed it), then the word is cleared.
- Branch during PRIME: takes effect. `req_pc`=`branch_addr` and the FSM enters RUN.
- Reset mid-operation: all registers return to reset values immediately (asynchronously). In-flight words are dropped.
- While `instr_valid`=1 & `instr_ready`=0 with no branch, `instr` and `instr_pc` must not change.

## Timing
- Reset release to first word:
  - Let E0 be the first rising edge after `rst` falls. The ROM latches address 0 at E0.
  - At E1, `instr`=mem[0], `instr_pc`=0, `instr_valid`=1.
- Steady state with `instr_ready`=1: one instruction per cycle, consecutive PCs.
- Branch asserted in cycle T:
  - `instr_valid`=0 during T+1.
  - `instr`=mem[`branch_addr`] valid from T+2.
  - Penalty is one bubble.
- Stall release: one word per cycle resumes the cycle after `instr_ready` rises, with no bubble.
- Combinational paths: `instr_ready`→`rom_addr` and `branch_en`/`branch_addr`→`rom_addr`. These are intentional, for zero-bubble streaming.

## Configuration
- `INSTR_FETCH_STALL_CNT_EN` defined:
  - Adds the `stall_cnt` port, a 32-bit counter that increments every cycle `instr_valid`=1 & `instr_ready`=0.
  - Saturates at 0xFFFFFFFF.
  - Cleared only by `rst`.
- Not defined: port and counter are absent. All other behaviour is identical.

## Test plan
- Reset release, ROM mem[i]=0x10000000+i, `instr_ready`=1:
  - `instr_valid` rises at E1 with `instr`=0x10000000, `instr_pc`=0.
  - Then 0x10000001…0x10000007 on consecutive cycles.
  - Then wrap to `instr_pc`=0, `instr`=0x10000000.
- Hold `instr_ready`=0 for 5 cycles while `instr_pc`=2:
  - `instr`=0x10000002 stable and `rom_addr`=3 throughout.
  - After release, `instr_pc` 3, 4 follow with no gap.
  - `stall_cnt`=5 when enabled.
- `branch_en`=1, `branch_addr`=6 while `instr_pc`=1:
  - One cycle with `instr_valid`=0.
  - Then `instr_pc`=6, 7, 0 with matching data.
- `branch_en`=1, `branch_addr`=4 with `instr_valid`=1 and `instr_ready`=0:
  - Stalled word dropped.
  - Next valid word is `instr_pc`=4, `instr`=0x10000004.
- Assert `rst` asynchronously mid-stream (between edges):
  - `instr_valid` and `req_pc` clear immediately.
  - After release, the sequence restarts at `instr_pc`=0 with E1 latency.
- `branch_en` during the PRIME cycle with `branch_addr`=5: first valid word is `instr_pc`=5, `instr`=0x10000005.

Source files
------------

// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, hides the ROM's registered read, hands words out over valid/ready.
// Optional stall counter port enabled by defining INSTR_FETCH_STALL_CNT_EN.
module instr_fetch #(
   parameter int ADDR_WIDTH = 3,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   output logic [ADDR_WIDTH-1:0] rom_addr,
   input  logic [DATA_WIDTH-1:0] rom_q,
   input  logic                  branch_en,
   input  logic [ADDR_WIDTH-1:0] branch_addr,
   output logic [DATA_WIDTH-1:0] instr,
   output logic [ADDR_WIDTH-1:0] instr_pc,
   output logic                  instr_valid,
   input  logic                  instr_ready
`ifdef INSTR_FETCH_STALL_CNT_EN
   ,
   output logic [31:0]           stall_cnt
`endif
);

   typedef enum logic {PRIME, RUN} state_t;

   state_t                state_reg, state_next;
   logic [ADDR_WIDTH-1:0] req_pc_reg;
   logic [ADDR_WIDTH-1:0] req_pc_inc;
   logic                  req_vld;
   logic                  advance;

   // rom_q carries a correct-path word exactly when the FSM has left PRIME
   assign req_vld    = (state_reg == RUN);
   assign advance    = req_vld & (~instr_valid | instr_ready);
   assign req_pc_inc = req_pc_reg + ADDR_WIDTH'(1);

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         PRIME:   state_next = RUN;
         RUN:     state_next = RUN;
         default: state_next = PRIME;
      endcase
   end

   // Re-presenting req_pc during a stall keeps rom_q stable for the held word
   always_comb begin
      rom_addr = req_pc_reg;
      if (rst)
         rom_addr = '0;
      else if (branch_en)
         rom_addr = branch_addr;
      else if (advance)
         rom_addr = req_pc_inc;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg   <= PRIME;
         req_pc_reg  <= '0;
         instr       <= '0;
         instr_pc    <= '0;
         instr_valid <= 1'b0;
      end else begin
         state_reg <= state_next;
         if (branch_en) begin
            req_pc_reg  <= branch_addr;
            instr_valid <= 1'b0;
         end else if (advance) begin
            instr       <= rom_q;
            instr_pc    <= req_pc_reg;
            instr_valid <= 1'b1;
            req_pc_reg  <= req_pc_inc;
         end else if (instr_valid && instr_ready && !req_vld) begin
            instr_valid <= 1'b0;
         end
      end
   end

`ifdef INSTR_FETCH_STALL_CNT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         stall_cnt <= '0;
      else if (instr_valid && !instr_ready && (stall_cnt != 32'hFFFF_FFFF))
         stall_cnt <= stall_cnt + 32'd1;
   end
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: ROM model plus a word-stream reference model.
// Build with INSTR_FETCH_STALL_CNT_EN to also check the stall counter.
module tb_instr_fetch;

   logic        clk = 1'b0;
   logic        rst;
   logic [2:0]  rom_addr;
   logic [31:0] rom_q;
   logic        branch_en;
   logic [2:0]  branch_addr;
   logic [31:0] instr;
   logic [2:0]  instr_pc;
   logic        instr_valid;
   logic        instr_ready;
`ifdef INSTR_FETCH_STALL_CNT_EN
   logic [31:0] stall_cnt;
`endif

   int errors = 0;
   int checks = 0;

   logic [31:0] mem [8];

   // reference model: the word on the output, the next PC to be issued, and priming delay
   logic        m_valid;
   logic [2:0]  m_pc;
   logic [31:0] m_data;
   logic [2:0]  m_next;
   int          m_wait;
   logic [31:0] m_cnt;
   logic [2:0]  exp_addr;
   logic [2:0]  obs_addr;

   always #5 clk = ~clk;

   always @(posedge clk) rom_q <= mem[rom_addr];

   instr_fetch #(.ADDR_WIDTH(3), .DATA_WIDTH(32)) dut (
      .clk(clk),
      .rst(rst),
      .rom_addr(rom_addr),
      .rom_q(rom_q),
      .branch_en(branch_en),
      .branch_addr(branch_addr),
      .instr(instr),
      .instr_pc(instr_pc),
      .instr_valid(instr_valid),
      .instr_ready(instr_ready)
`ifdef INSTR_FETCH_STALL_CNT_EN
      ,
      .stall_cnt(stall_cnt)
`endif
   );

   task automatic model_reset();
      m_valid = 1'b0;
      m_pc    = '0;
      m_data  = '0;
      m_next  = '0;
      m_wait  = 1;
      m_cnt   = '0;
   endtask

   // Drives one cycle of inputs, steps the model at the edge, returns at the following negedge
   task automatic cycle(input logic b, input logic [2:0] a, input logic r);
      logic adv;
      branch_en   = b;
      branch_addr = a;
      instr_ready = r;
      #1;
      obs_addr = rom_addr;
      adv = (m_wait == 0) && (!m_valid || r);
      exp_addr = b ? a : (adv ? 3'(m_next + 3'd1) : m_next);
      @(posedge clk);
      if (m_valid && r)
         $display("t=%0t accept pc=%0d instr=%h", $time, m_pc, m_data);
      if (m_valid && !r && m_cnt != 32'hFFFF_FFFF)
         m_cnt = m_cnt + 1;
      if (b) begin
         m_valid = 1'b0;
         m_next  = a;
         m_wait  = 0;
      end else if (m_wait > 0) begin
         m_wait = m_wait - 1;
      end else if (adv) begin
         m_valid = 1'b1;
         m_pc    = m_next;
         m_data  = mem[m_next];
         m_next  = m_next + 3'd1;
      end
      @(negedge clk);
   endtask

   task automatic fill_mem_seq();
      for (int i = 0; i < 8; i++) mem[i] = 32'h1000_0000 + i;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      branch_en = 1'b0; branch_addr = '0; instr_ready = 1'b0;
      fill_mem_seq();
      model_reset();
      repeat (2) @(negedge clk);
      checks++;
      if (instr_valid !== 1'b0 || instr !== 32'd0 || instr_pc !== 3'd0)
         begin errors++; $display("FAIL reset_outputs: valid=%b pc=%0d instr=%h required 0/0/0", instr_valid, instr_pc, instr); end
      checks++;
      if (rom_addr !== 3'd0)
         begin errors++; $display("FAIL reset_rom_addr: got %0d required 0", rom_addr); end
`ifdef INSTR_FETCH_STALL_CNT_EN
      checks++;
      if (stall_cnt !== 32'd0)
         begin errors++; $display("FAIL reset_stall_cnt: got %0d required 0", stall_cnt); end
`endif
      rst = 1'b0;
   endtask

   task automatic test_stream();
      for (int i = 0; i < 10; i++) begin
         cycle(1'b0, 3'd0, 1'b1);
         checks++;
         if (instr_valid !== m_valid)
            begin errors++; $display("FAIL stream_valid: cyc=%0d got %b required %b", i, instr_valid, m_valid); end
         if (m_valid) begin
            checks++;
            if (instr_pc !== m_pc || instr !== m_data)
               begin errors++; $display("FAIL stream_word: cyc=%0d got pc=%0d %h required pc=%0d %h", i, instr_pc, instr, m_pc, m_data); end
         end
         checks++;
         if (obs_addr !== exp_addr)
            begin errors++; $display("FAIL stream_rom_addr: cyc=%0d got %0d required %0d", i, obs_addr, exp_addr); end
         if (i == 1) begin
            checks++;
            if (instr_valid !== 1'b1 || instr_pc !== 3'd0 || instr !== 32'h1000_0000)
               begin errors++; $display("FAIL first_word_E1: got v=%b pc=%0d %h required 1/0/10000000", instr_valid, instr_pc, instr); end
         end
         if (i == 9) begin
            checks++;
            if (instr_pc !== 3'd0 || instr !== 32'h1000_0000)
               begin errors++; $display("FAIL wrap_word: got pc=%0d %h required pc=0 10000000", instr_pc, instr); end
         end
      end
   endtask

   task automatic test_stall();
      for (int i = 0; i < 16 && !(m_valid && m_pc == 3'd2); i++) cycle(1'b0, 3'd0, 1'b1);
      checks++;
      if (instr_pc !== 3'd2 || instr_valid !== 1'b1)
         begin errors++; $display("FAIL stall_setup: got pc=%0d v=%b required pc=2 v=1", instr_pc, instr_valid); end
      for (int i = 0; i < 5; i++) begin
         cycle(1'b0, 3'd0, 1'b0);
         checks++;
         if (instr !== 32'h1000_0002 || instr_pc !== 3'd2 || instr_valid !== 1'b1)
            begin errors++; $display("FAIL stall_hold: cyc=%0d got pc=%0d %h required pc=2 10000002", i, instr_pc, instr); end
         checks++;
         if (obs_addr !== 3'd3)
            begin errors++; $display("FAIL stall_rom_addr: cyc=%0d got %0d required 3", i, obs_addr); end
      end
      for (int i = 0; i < 2; i++) begin
         cycle(1'b0, 3'd0, 1'b1);
         checks++;
         if (instr_valid !== 1'b1 || instr_pc !== 3'(3 + i) || instr !== mem[3 + i])
            begin errors++; $display("FAIL stall_release: cyc=%0d got v=%b pc=%0d %h required pc=%0d", i, instr_valid, instr_pc, instr, 3 + i); end
      end
`ifdef INSTR_FETCH_STALL_CNT_EN
      checks++;
      if (stall_cnt !== 32'd5 || stall_cnt !== m_cnt)
         begin errors++; $display("FAIL stall_cnt: got %0d required 5", stall_cnt); end
`endif
   endtask

   task automatic test_branch();
      for (int i = 0; i < 16 && !(m_valid && m_pc == 3'd1); i++) cycle(1'b0, 3'd0, 1'b1);
      cycle(1'b1, 3'd6, 1'b1);
      checks++;
      if (instr_valid !== 1'b0)
         begin errors++; $display("FAIL branch_bubble: got valid=%b required 0", instr_valid); end
      checks++;
      if (obs_addr !== 3'd6)
         begin errors++; $display("FAIL branch_rom_addr: got %0d required 6", obs_addr); end
      for (int i = 0; i < 3; i++) begin
         cycle(1'b0, 3'd0, 1'b1);
         checks++;
         if (instr_valid !== 1'b1 || instr_pc !== 3'(6 + i) || instr !== mem[3'(6 + i)])
            begin errors++; $display("FAIL branch_target: cyc=%0d got v=%b pc=%0d %h required pc=%0d", i, instr_valid, instr_pc, instr, 3'(6 + i)); end
      end
   endtask

   task automatic test_branch_during_stall();
      cycle(1'b0, 3'd0, 1'b0);
      cycle(1'b1, 3'd4, 1'b0);
      checks++;
      if (instr_valid !== 1'b0)
         begin errors++; $display("FAIL bstall_drop: got valid=%b required 0", instr_valid); end
      cycle(1'b0, 3'd0, 1'b0);
      checks++;
      if (instr_valid !== 1'b1 || instr_pc !== 3'd4 || instr !== 32'h1000_0004)
         begin errors++; $display("FAIL bstall_next: got v=%b pc=%0d %h required 1/4/10000004", instr_valid, instr_pc, instr); end
      cycle(1'b0, 3'd0, 1'b1);
   endtask

   task automatic test_async_reset();
      cycle(1'b0, 3'd0, 1'b1);
      #2 rst = 1'b1;
      #1;
      checks++;
      if (instr_valid !== 1'b0 || rom_addr !== 3'd0)
         begin errors++; $display("FAIL async_reset: got valid=%b rom_addr=%0d required 0/0", instr_valid, rom_addr); end
      @(negedge clk);
      #2 rst = 1'b0;
      model_reset();
      #1;
      checks++;
      if (rom_addr !== 3'd0 || instr_valid !== 1'b0)
         begin errors++; $display("FAIL reset_release_pc: got rom_addr=%0d valid=%b required 0/0", rom_addr, instr_valid); end
      for (int i = 0; i < 3; i++) begin
         cycle(1'b0, 3'd0, 1'b1);
         checks++;
         if (instr_valid !== m_valid || (m_valid && (instr_pc !== m_pc || instr !== m_data)))
            begin errors++; $display("FAIL restart: cyc=%0d got v=%b pc=%0d %h required v=%b pc=%0d %h", i, instr_valid, instr_pc, instr, m_valid, m_pc, m_data); end
      end
      checks++;
      if (instr_pc !== 3'd1)
         begin errors++; $display("FAIL restart_latency: got pc=%0d required 1", instr_pc); end
   endtask

   task automatic test_prime_branch();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      cycle(1'b1, 3'd5, 1'b1);
      checks++;
      if (instr_valid !== 1'b0)
         begin errors++; $display("FAIL prime_branch_bubble: got valid=%b required 0", instr_valid); end
      cycle(1'b0, 3'd0, 1'b1);
      checks++;
      if (instr_valid !== 1'b1 || instr_pc !== 3'd5 || instr !== 32'h1000_0005)
         begin errors++; $display("FAIL prime_branch_word: got v=%b pc=%0d %h required 1/5/10000005", instr_valid, instr_pc, instr); end
   endtask

   task automatic test_random();
      @(negedge clk);
      rst = 1'b1;
      for (int i = 0; i < 8; i++) mem[i] = $urandom;
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      for (int i = 0; i < 300; i++) begin
         cycle(($urandom_range(0, 5) == 0), 3'($urandom_range(0, 7)), ($urandom_range(0, 9) < 7));
         checks++;
         if (instr_valid !== m_valid)
            begin errors++; $display("FAIL rand_valid: cyc=%0d got %b required %b", i, instr_valid, m_valid); end
         if (m_valid) begin
            checks++;
            if (instr_pc !== m_pc || instr !== m_data)
               begin errors++; $display("FAIL rand_word: cyc=%0d got pc=%0d %h required pc=%0d %h", i, instr_pc, instr, m_pc, m_data); end
         end
         checks++;
         if (obs_addr !== exp_addr)
            begin errors++; $display("FAIL rand_rom_addr: cyc=%0d got %0d required %0d", i, obs_addr, exp_addr); end
`ifdef INSTR_FETCH_STALL_CNT_EN
         checks++;
         if (stall_cnt !== m_cnt)
            begin errors++; $display("FAIL rand_stall_cnt: cyc=%0d got %0d required %0d", i, stall_cnt, m_cnt); end
`endif
      end
   endtask

   initial begin
      test_reset();
      test_stream();
      test_stall();
      test_branch();
      test_branch_during_stall();
      test_async_reset();
      test_prime_branch();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
